cdb_arbiter: RTL
================

# cdb_arbiter

Common Data Bus arbiter and broadcast register for the Tomasulo core. It is the responding end of the functional units' `require`/`requireAC` handshake. Each cycle it grants at most one requesting unit (ALU, MUL, DIV, LS) using a round-robin policy and latches that unit's result and label. On the next cycle it drives the result and label as the single CDB broadcast (`BCEN`/`BCdata`/`BClabel`) to the reservation stations and the register file.

## Interface
Parameters:
- `N_SRC`, 4: number of requesting units. Index 0 = ALU, 1 = MUL, 2 = DIV, 3 = LS.
- `DATA_W`, 32: result width.
- `LABEL_W`, 4: reservation-station label width. Label 0 means "no producer".

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `nRST`  in  1  reset. Synchronous and active-high (asserted = 1), despite the name.
- `require`  in  N_SRC  per-unit request. Unit i holds bit i high while it has a finished result.
- `dataIn`  in  N_SRC*DATA_W  results, flattened. Unit i occupies bits [i*DATA_W +: DATA_W].
- `labelIn`  in  N_SRC*LABEL_W  producer labels, flattened the same way.
- `hold`  in  1  freeze arbitration; no grants are issued while it is high.
- `requireAC`  out  N_SRC  one-hot grant, combinational, same cycle as the request.
- `BCEN`  out  1  broadcast valid (registered).
- `BCdata`  out  DATA_W  broadcast result (registered).
- `BClabel`  out  LABEL_W  broadcast label (registered).
- `labelErr`  out  1  sticky flag: a granted request carried label 0.

## Operation
- **Round-robin pointer.** `ptr` (log2 N_SRC bits, reset 0) is the highest-priority index for the current cycle.
- **Grant selection.**
  - The grant goes to the first asserted `require[i]`, scanning i = ptr, ptr+1, … modulo N_SRC (wrap-around).
  - `requireAC` is one-hot, or all-zero when no request is asserted.
  - `requireAC` is forced to zero while `hold` = 1 or `nRST` = 1.
- **Pointer update.** On a grant to index g, `ptr` ← (g+1) mod N_SRC. With no grant, `ptr` is unchanged.
- **Broadcast latch.** On a grant to g, at the next edge:
  - `BCdata` ← dataIn[g]
  - `BClabel` ← labelIn[g]
  - `BCEN` ← 1, except `BCEN` ← 0 if labelIn[g] = 0.
- **No grant.** `BCEN` ← 0. `BCdata` and `BClabel` hold their previous values.
- **Label-0 grant.** The request is still acknowledged, so the unit does not deadlock, but the broadcast is suppressed and `labelErr` ← 1. `labelErr` clears only on reset.
- **Requester contract.**
  - A unit keeps `require`, `dataIn` and `labelIn` stable until it sees `requireAC` high.
  - In the cycle after the grant, it either drops `require` or presents a new result.
  - The arbiter never grants the same unit twice for one result, because the grant is consumed at the edge.
- **Simultaneous events.**
  - Several requests in one cycle: only one is granted; the others stay pending and wait.
  - The round-robin order guarantees every requester is granted within N_SRC cycles of continuous requesting, provided `hold` = 0.
- **Reset.**
  - Synchronous reset clears `ptr`, `BCEN`, `BCdata`, `BClabel` and `labelErr` to 0.
  - A broadcast latched in the cycle before reset is discarded: `BCEN` is 0 in the cycle after the reset edge.

## Timing
- Grant latency is 0 cycles: `requireAC` is combinational from `require`, `ptr`, `hold` and `nRST`.
- Broadcast latency is 1 cycle: data granted in cycle t is on the CDB with `BCEN` = 1 in cycle t+1, for exactly one cycle unless a new grant follows.
- Throughput is one broadcast per cycle: back-to-back grants produce back-to-back `BCEN` = 1 cycles.
- Combinational path: `require` → `requireAC` only. All CDB outputs are flop outputs.
- Reset values:
  - `requireAC` = 0
  - `BCEN` = 0, `BCdata` = 0, `BClabel` = 0
  - `labelErr` = 0
  - `ptr` = 0

## Test plan
- **Single request.** After reset, require = 0001, data0 = 0x0000_00AA, label0 = 3.
  - Same cycle: requireAC = 0001.
  - Next cycle: BCEN = 1, BCdata = 0xAA, BClabel = 3.
  - Following cycle (require dropped): BCEN = 0.
- **Contention.** require = 1111 held for 4 cycles, each unit presenting label i+1.
  - Grants in order 0001, 0010, 0100, 1000.
  - BClabel sequence 1, 2, 3, 4 on consecutive cycles; BCEN stays 1 throughout.
- **Fairness and wrap.** ptr = 3 (after one grant to unit 2), require = 1001.
  - Grant goes to unit 3 first, then unit 0 on the next cycle.
- **Hold.** hold = 1 with require = 0100 for 3 cycles.
  - requireAC = 0 and BCEN = 0 throughout.
  - The cycle hold falls: requireAC = 0100. BCEN = 1 one cycle later.
- **Label 0.** require = 0010 with label1 = 0.
  - requireAC = 0010 is issued.
  - Next cycle: BCEN = 0 and labelErr = 1; labelErr stays 1 until reset.
- **Reset mid-operation.** Grant unit 0 in cycle t, assert nRST = 1 in cycle t.
  - Cycle t+1: BCEN = 0, BCdata = 0, ptr = 0.
  - requireAC = 0 while nRST = 1.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the Common Data Bus.
// Grants one requesting functional unit per cycle (combinational ack).
// Latches the winner's result and label, and broadcasts them on the
// following cycle. A grant carrying label 0 is still acknowledged, but
// its broadcast is suppressed and the sticky labelErr flag is raised.
module cdb_arbiter #(
    parameter int N_SRC   = 4,
    parameter int DATA_W  = 32,
    parameter int LABEL_W = 4
) (
    input  logic                       clk,
    input  logic                       nRST,
    input  logic [N_SRC-1:0]           require,
    input  logic [N_SRC*DATA_W-1:0]    dataIn,
    input  logic [N_SRC*LABEL_W-1:0]   labelIn,
    input  logic                       hold,
    output logic [N_SRC-1:0]           requireAC,
    output logic                       BCEN,
    output logic [DATA_W-1:0]          BCdata,
    output logic [LABEL_W-1:0]         BClabel,
    output logic                       labelErr
);

    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [PTR_W-1:0]   r_ptr;
    logic               r_bcen;
    logic [DATA_W-1:0]  r_bcdata;
    logic [LABEL_W-1:0] r_bclabel;
    logic               r_label_err;

    logic               w_found;
    logic [PTR_W-1:0]   w_gidx;
    logic [N_SRC-1:0]   w_grant;
    logic [DATA_W-1:0]  w_gdata;
    logic [LABEL_W-1:0] w_glabel;
    logic [PTR_W-1:0]   w_ptr_next;

    // Scan requests starting at r_ptr with wrap-around; first hit wins.
    // Reset and hold both suppress the grant entirely.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_gidx  = '0;
        w_grant = '0;
        idx     = 0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end
            if (!w_found && require[idx]) begin
                w_found = 1'b1;
                w_gidx  = idx[PTR_W-1:0];
            end
        end
        if (hold || nRST) begin
            w_found = 1'b0;
        end
        if (w_found) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    // Select the winning unit's payload and the next priority index.
    always_comb begin
        w_gdata    = dataIn[w_gidx*DATA_W +: DATA_W];
        w_glabel   = labelIn[w_gidx*LABEL_W +: LABEL_W];
        w_ptr_next = (w_gidx == PTR_W'(N_SRC - 1)) ? '0 : w_gidx + 1'b1;
    end

    // Pointer advance, broadcast latch and sticky label-0 error flag.
    always_ff @(posedge clk) begin
        if (nRST) begin
            r_ptr       <= '0;
            r_bcen      <= 1'b0;
            r_bcdata    <= '0;
            r_bclabel   <= '0;
            r_label_err <= 1'b0;
        end else if (w_found) begin
            r_ptr     <= w_ptr_next;
            r_bcdata  <= w_gdata;
            r_bclabel <= w_glabel;
            r_bcen    <= (w_glabel != '0);
            if (w_glabel == '0) begin
                r_label_err <= 1'b1;
            end
        end else begin
            r_bcen <= 1'b0;
        end
    end

    assign requireAC = w_grant;
    assign BCEN      = r_bcen;
    assign BCdata    = r_bcdata;
    assign BClabel   = r_bclabel;
    assign labelErr  = r_label_err;

endmodule
